// File: rtl/univ_shift_reg.sv
// Universal shift register: load, logical shift, rotate, set and clear, with a
// saturating shift counter. Define UNIV_SR_PARITY_EN to add the registered PAR output.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             ZERO,
    output logic [CNT_W-1:0] CNT
`ifdef UNIV_SR_PARITY_EN
    ,
    output logic             PAR
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_SET  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_sat;

    // The counter sticks at all-ones instead of wrapping.
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        q_d   = q_q;
        so_d  = so_q;
        cnt_d = cnt_q;
        if (EN) begin
            unique case (mode_e'(MODE))
                MODE_HOLD: ;
                MODE_LOAD: begin
                    q_d   = D;
                    so_d  = 1'b0;
                    cnt_d = '0;
                end
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], SI};
                    so_d  = q_q[WIDTH-1];
                    cnt_d = cnt_sat;
                end
                MODE_SHR: begin
                    q_d   = {SI, q_q[WIDTH-1:1]};
                    so_d  = q_q[0];
                    cnt_d = cnt_sat;
                end
                MODE_ROL: begin
                    q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d  = q_q[WIDTH-1];
                    cnt_d = cnt_sat;
                end
                MODE_ROR: begin
                    q_d   = {q_q[0], q_q[WIDTH-1:1]};
                    so_d  = q_q[0];
                    cnt_d = cnt_sat;
                end
                MODE_SET: begin
                    q_d   = '1;
                    so_d  = 1'b0;
                    cnt_d = '0;
                end
                MODE_CLR: begin
                    q_d   = RESET_VAL;
                    so_d  = 1'b0;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Flag derives from the next value of Q so it lands on the same edge as Q.
        zero_d = ~|q_d;
    end

    always_ff @(posedge C) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (R) begin
            q_q    <= RESET_VAL;
            so_q   <= 1'b0;
            zero_q <= (RESET_VAL == '0);
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            so_q   <= so_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef UNIV_SR_PARITY_EN
    logic par_q;

    always_ff @(posedge C) begin
        if (R) par_q <= ^RESET_VAL;
        else   par_q <= ^q_d;
    end

    assign PAR = par_q;
`endif

    assign Q    = q_q;
    assign SO   = so_q;
    assign ZERO = zero_q;
    assign CNT  = cnt_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: a table of hand-computed vectors, directed corner
// sequences and random traffic, checked through a model-fed scoreboard queue.
module tb_univ_shift_reg;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       EN = 1'b0;
    logic [2:0] MODE = 3'd0;
    logic [7:0] D = 8'h00;
    logic       SI = 1'b0;

    logic [7:0] q_a, q_b;
    logic       so_a, so_b, zero_a, zero_b;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;
`ifdef UNIV_SR_PARITY_EN
    logic       par_a, par_b;
`endif

    always #5 C = ~C;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) dut_a (
        .C(C), .R(R), .EN(EN), .MODE(MODE), .D(D), .SI(SI),
        .Q(q_a), .SO(so_a), .ZERO(zero_a), .CNT(cnt_a)
`ifdef UNIV_SR_PARITY_EN
        , .PAR(par_a)
`endif
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(3)) dut_b (
        .C(C), .R(R), .EN(EN), .MODE(MODE), .D(D), .SI(SI),
        .Q(q_b), .SO(so_b), .ZERO(zero_b), .CNT(cnt_b)
`ifdef UNIV_SR_PARITY_EN
        , .PAR(par_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] q_a;  logic so_a; int cnt_a;
        logic [7:0] q_b;  logic so_b; int cnt_b;
    } exp_t;

    exp_t m;
    exp_t sb_q[$];

    task automatic apply_op(input logic [2:0] mode, input logic [7:0] d, input logic si,
                            input logic [7:0] rv, input int cmax,
                            inout logic [7:0] q, inout logic so, inout int cnt);
        logic [7:0] old;
        old = q;
        case (mode)
            3'd1: begin q = d;     so = 1'b0; cnt = 0; end
            3'd2: begin q = {old[6:0], si};     so = old[7]; if (cnt < cmax) cnt++; end
            3'd3: begin q = {si, old[7:1]};     so = old[0]; if (cnt < cmax) cnt++; end
            3'd4: begin q = {old[6:0], old[7]}; so = old[7]; if (cnt < cmax) cnt++; end
            3'd5: begin q = {old[0], old[7:1]}; so = old[0]; if (cnt < cmax) cnt++; end
            3'd6: begin q = 8'hFF; so = 1'b0; cnt = 0; end
            3'd7: begin q = rv;    so = 1'b0; cnt = 0; end
            default: ;
        endcase
    endtask

    task automatic step(input logic r, input logic en, input logic [2:0] mode,
                        input logic [7:0] d, input logic si);
        @(negedge C);
        R = r; EN = en; MODE = mode; D = d; SI = si;
        if (r) begin
            m.q_a = 8'hA5; m.so_a = 1'b0; m.cnt_a = 0;
            m.q_b = 8'h00; m.so_b = 1'b0; m.cnt_b = 0;
        end else if (en) begin
            apply_op(mode, d, si, 8'hA5, 255, m.q_a, m.so_a, m.cnt_a);
            apply_op(mode, d, si, 8'h00, 7,   m.q_b, m.so_b, m.cnt_b);
        end
        sb_q.push_back(m);
    endtask

    // Scoreboard: one expected record per edge, compared just after that edge.
    always @(posedge C) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_q_a",    64'(q_a),    64'(e.q_a));
            check("sb_so_a",   64'(so_a),   64'(e.so_a));
            check("sb_cnt_a",  64'(cnt_a),  64'(e.cnt_a));
            check("sb_zero_a", 64'(zero_a), 64'(e.q_a == 8'h00));
            check("sb_q_b",    64'(q_b),    64'(e.q_b));
            check("sb_so_b",   64'(so_b),   64'(e.so_b));
            check("sb_cnt_b",  64'(cnt_b),  64'(e.cnt_b));
            check("sb_zero_b", 64'(zero_b), 64'(e.q_b == 8'h00));
`ifdef UNIV_SR_PARITY_EN
            check("sb_par_a",  64'(par_a),  64'(^e.q_a));
            check("sb_par_b",  64'(par_b),  64'(^e.q_b));
`endif
        end
    end

    // ---------------- hand-computed vectors for dut_a (RESET_VAL=A5) ----------------
    typedef struct {
        logic       r, en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       si;
        logic [7:0] q;
        logic       so;
        logic [7:0] cnt;
        logic       zero;
    } vec_t;

    vec_t vecs[13];

    initial begin
        //            r     en    mode  d      si    q      so    cnt    zero
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 8'h81, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 8'h02, 1'b1, 8'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 8'h81, 1'b0, 8'd2, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h81, 1'b0, 8'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 8'h03, 1'b1, 8'd3, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'h81, 1'b1, 8'd4, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 8'h81, 1'b1, 8'd4, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'hFF, 1'b0, 8'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'hA5, 1'b0, 8'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 8'hA5, 1'b0, 8'd0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].r, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].si);
            @(posedge C); #2;
            check($sformatf("vec%0d_q", i),    64'(q_a),    64'(vecs[i].q));
            check($sformatf("vec%0d_so", i),   64'(so_a),   64'(vecs[i].so));
            check($sformatf("vec%0d_cnt", i),  64'(cnt_a),  64'(vecs[i].cnt));
            check($sformatf("vec%0d_zero", i), 64'(zero_a), 64'(vecs[i].zero));
        end

        // Rotate a single one all the way round.
        step(1'b0, 1'b1, 3'd1, 8'h01, 1'b0);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        @(posedge C); #2;
        check("ror_first_so", 64'(so_a), 64'(1));
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        @(posedge C); #2;
        check("ror8_q",   64'(q_a),   64'(8'h01));
        check("ror8_cnt", 64'(cnt_a), 64'(8));

        // Narrow counter saturates at 7 while Q drains to zero.
        step(1'b0, 1'b1, 3'd1, 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
        @(posedge C); #2;
        check("sat_cnt_b",  64'(cnt_b),  64'(7));
        check("sat_q_b",    64'(q_b),    64'(8'h00));
        check("sat_zero_b", 64'(zero_b), 64'(1));
        check("sat_cnt_a",  64'(cnt_a),  64'(10));

        // Enable low blocks SET; then reset beats an enabled ROL mid-sequence.
        step(1'b0, 1'b1, 3'd1, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd6, 8'hFF, 1'b1);
        @(posedge C); #2;
        check("hold_q",   64'(q_a),   64'(8'h79));
        check("hold_cnt", 64'(cnt_a), 64'(1));
        step(1'b1, 1'b1, 3'd4, 8'h00, 1'b0);
        @(posedge C); #2;
        check("rst_prio_q",   64'(q_a),   64'(8'hA5));
        check("rst_prio_cnt", 64'(cnt_a), 64'(0));

`ifdef UNIV_SR_PARITY_EN
        step(1'b0, 1'b1, 3'd1, 8'h07, 1'b0);
        @(posedge C); #2;
        check("par_load07", 64'(par_a), 64'(1));
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
        @(posedge C); #2;
        check("par_set", 64'(par_a), 64'(0));
        check("par_set_q", 64'(q_a), 64'(8'hFF));
`endif

        // Random traffic, checked only through the scoreboard.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 5) != 0,
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        repeat (3) @(posedge C);
        #2;
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into Q by reset and by mode CLR.
REQ-003 Parameter CNT_W, default 8: width of the shift counter CNT.
REQ-004 C  input  1  clock; all state updates on posedge C.
REQ-005 R  input  1  reset; synchronous, active-high, sampled on posedge C.
REQ-006 EN  input  1  operation enable; when 0, all state holds.
REQ-007 MODE  input  3  operation select, sampled when EN=1.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 SI  input  1  serial input for logical shifts.
REQ-010 Q  output  WIDTH  register contents; direct flop output.
REQ-011 SO  output  1  serial out: Q[WIDTH-1] after SHL/ROL, Q[0] after SHR/ROR; registered.
REQ-012 ZERO  output  1  registered flag; 1 when Q == 0.
REQ-013 CNT  output  CNT_W  number of shift/rotate operations since the last LOAD, SET, CLR or reset.

Function
REQ-014 Each operation SHALL take effect on the first posedge C at which EN=1 and R=0; latency is 1 cycle, and Q, SO, ZERO and CNT SHALL update on the same edge.
REQ-015 MODE encoding SHALL be: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 SET, 7 CLR.
REQ-016 HOLD SHALL leave Q, SO and CNT unchanged.
REQ-017 LOAD SHALL set Q=D, SO=0 and CNT=0.
REQ-018 SHL SHALL set Q={Q[WIDTH-2:0],SI} and SO=old Q[WIDTH-1].
REQ-019 SHR SHALL set Q={SI,Q[WIDTH-1:1]} and SO=old Q[0].
REQ-020 ROL SHALL set Q={Q[WIDTH-2:0],Q[WIDTH-1]} and SO=old Q[WIDTH-1].
REQ-021 ROR SHALL set Q={Q[0],Q[WIDTH-1:1]} and SO=old Q[0].
REQ-022 SET SHALL set Q to all ones, SO=0 and CNT=0.
REQ-023 CLR SHALL set Q=RESET_VAL, SO=0 and CNT=0.
REQ-024 Modes 2-5 SHALL increment CNT by 1; CNT SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 ZERO SHALL equal the reduction NOR of the next value of Q, registered alongside Q, so ZERO never lags Q.
REQ-026 EN=0 SHALL hold every output regardless of MODE, D or SI.
REQ-027 Q SHALL depend only on registered state; there is no combinational path from D, SI or MODE to any output.

Reset
REQ-028 On posedge C with R=1: Q=RESET_VAL, SO=0, CNT=0, and ZERO=(RESET_VAL==0).
REQ-029 R SHALL take priority over EN and MODE, including in the middle of a shift sequence; the sequence is abandoned and CNT returns to 0.
REQ-030 Asserting R SHALL have no asynchronous effect; outputs are unchanged between clock edges.

Configuration
REQ-031 With UNIV_SR_PARITY_EN defined, the block SHALL add output PAR (1 bit), registered, equal to the XOR reduction of Q, updated on the same edge as Q, with reset value ^RESET_VAL.
REQ-032 Without UNIV_SR_PARITY_EN, the PAR port and its flop SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset: WIDTH=8, RESET_VAL=8'hA5, R=1 for 1 edge -> Q=8'hA5, SO=0, CNT=0, ZERO=0, PAR=0 (if enabled).
REQ-034 Shift: LOAD D=8'h81, then SHL with SI=0 -> Q=8'h02, SO=1, CNT=1; then SHR with SI=1 -> Q=8'h81, SO=0, CNT=2.
REQ-035 Rotate: LOAD 8'h01, then ROR 8 times -> Q returns to 8'h01, CNT=8, ZERO never asserts; SO=1 after the first ROR.
REQ-036 Saturation: CNT_W=3, LOAD, then SHL 10 times with SI=0 -> CNT stops at 7; Q=8'h00 and ZERO=1 from the 8th shift onward.
REQ-037 Hold/priority: EN=0 with MODE=SET for 5 cycles -> Q unchanged; EN=1, MODE=ROL with R=1 on the same edge -> Q=RESET_VAL, CNT=0.
REQ-038 Parity build: UNIV_SR_PARITY_EN defined, LOAD 8'h07 -> PAR=1; SET -> PAR=0, Q=8'hFF; CLR -> Q=RESET_VAL.
